fft_2d_frame_sink: RTL and testbench

- Receive side of the 2-D FFT output interface: captures each complete WIDTH x WIDTH complex result tile announced by the next_out pulse.
- Holds tiles in a two-bank ping-pong buffer.
- Drains each tile row by row over a valid/ready stream to the downstream convolution (pointwise-multiply) stage.
- Absorbs the FFT's fixed-timing, non-stallable output and reports dropped frames.

---
 rtl/fft_2d_pkg.sv | 37 +++
 rtl/fft_frame_bank2.sv | 71 +++++++
 rtl/fft_2d_frame_sink.sv | 107 ++++++++++
 tb/tb_fft_2d_frame_sink.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_2d_pkg.sv
// Types and helpers shared by the 2-D FFT and its frame sink.
// Tiles pack row i at slot i and element j at slot j within a row, with the real part low.
package fft_2d_pkg;

    localparam int CPLX_DATA_W          = 16;
    localparam int NUM_SUPPORTED_WIDTHS = 3;
    localparam int SUPPORTED_WIDTHS [NUM_SUPPORTED_WIDTHS] = '{4, 8, 16};

    typedef struct packed {
        logic [CPLX_DATA_W-1:0] im;
        logic [CPLX_DATA_W-1:0] re;
    } cplx_t;

    function automatic int row_bits(input int width, input int data_w);
        return width * 2 * data_w;
    endfunction

    function automatic int row_lsb(input int row, input int width, input int data_w);
        return row * row_bits(width, data_w);
    endfunction

    function automatic int elem_lsb(input int col, input int data_w);
        return col * 2 * data_w;
    endfunction

    function automatic bit is_supported_width(input int width);
        bit found;
        found = 1'b0;
        for (int i = 0; i < NUM_SUPPORTED_WIDTHS; i++) begin
            if (SUPPORTED_WIDTHS[i] == width) begin
                found = 1'b1;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/fft_frame_bank2.sv
// Two-bank ping-pong tile store: whole tiles written in one cycle, read back one row at a time.
// The caller guarantees a write only lands when a bank is free or the head bank is popped that cycle.
module fft_frame_bank2
    import fft_2d_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_en_i,
    input  logic [WIDTH*WIDTH*2*DATA_W-1:0]     wr_tile_i,
    input  logic                                rd_pop_i,
    input  logic [$clog2(WIDTH)-1:0]            rd_row_i,
    output logic [WIDTH*2*DATA_W-1:0]           rd_data_o,
    output logic [1:0]                          occupancy_o
);

    localparam int ROW_W  = WIDTH * 2 * DATA_W;
    localparam int TILE_W = WIDTH * ROW_W;

    logic [TILE_W-1:0] bank_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        occ_q;
    logic [1:0]        occ_d;
    logic [TILE_W-1:0] head_tile;
    logic [ROW_W-1:0]  head_rows [WIDTH];

    always_comb begin
        occ_d = occ_q;
        case ({wr_en_i, rd_pop_i})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (rd_pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

    // Storage carries no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            bank_q[wr_ptr_q] <= wr_tile_i;
        end
    end

    assign head_tile = bank_q[rd_ptr_q];

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
        assign head_rows[gi] = head_tile[row_lsb(gi, WIDTH, DATA_W) +: ROW_W];
    end

    assign rd_data_o   = head_rows[rd_row_i];
    assign occupancy_o = occ_q;

endmodule

// File: rtl/fft_2d_frame_sink.sv
// Captures 2-D FFT result tiles one cycle after next_out and drains them row by row
// over a valid/ready stream; frames arriving with both banks busy are dropped and counted.
module fft_2d_frame_sink
    import fft_2d_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                next_out,
    input  logic [WIDTH*WIDTH*2*DATA_W-1:0]     frame_in,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [WIDTH*2*DATA_W-1:0]           m_data,
    output logic [$clog2(WIDTH)-1:0]            m_row,
    output logic                                m_last,
    output logic [1:0]                          occupancy,
    output logic                                overflow,
    input  logic                                clr_ovf,
    output logic [7:0]                          drop_cnt
);

    localparam int RW    = $clog2(WIDTH);
    localparam int ROW_W = WIDTH * 2 * DATA_W;

    logic              capture_pend_q;
    logic [RW-1:0]     row_q;
    logic [RW-1:0]     row_d;
    logic              overflow_q;
    logic              overflow_d;
    logic [7:0]        drop_cnt_q;
    logic [7:0]        drop_cnt_d;
    logic [1:0]        occ;
    logic [ROW_W-1:0]  rd_data;
    logic              beat_xfer;
    logic              last_xfer;
    logic              accept;
    logic              drop;

    fft_frame_bank2 #(
        .WIDTH  (WIDTH),
        .DATA_W (DATA_W)
    ) u_banks (
        .clk         (clk),
        .rst_n       (reset),
        .wr_en_i     (accept),
        .wr_tile_i   (frame_in),
        .rd_pop_i    (last_xfer),
        .rd_row_i    (row_q),
        .rd_data_o   (rd_data),
        .occupancy_o (occ)
    );

    assign beat_xfer = m_valid && m_ready;
    assign last_xfer = beat_xfer && (row_q == RW'(WIDTH - 1));
    // A full store can still take a frame if the head bank frees up in the same cycle.
    assign accept    = capture_pend_q && ((occ < 2'd2) || last_xfer);
    assign drop      = capture_pend_q && !accept;

    always_comb begin
        row_d = row_q;
        if (last_xfer) begin
            row_d = '0;
        end else if (beat_xfer) begin
            row_d = row_q + RW'(1);
        end
    end

    // A drop in the same cycle as a clear leaves exactly one recorded drop.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_ovf) begin
            overflow_d = drop;
            drop_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            capture_pend_q <= 1'b0;
            row_q          <= '0;
            overflow_q     <= 1'b0;
            drop_cnt_q     <= 8'd0;
        end else begin
            capture_pend_q <= next_out;
            row_q          <= row_d;
            overflow_q     <= overflow_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    assign m_valid   = (occ != 2'd0);
    assign m_data    = m_valid ? rd_data : '0;
    assign m_row     = row_q;
    assign m_last    = m_valid && (row_q == RW'(WIDTH - 1));
    assign occupancy = occ;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fft_2d_frame_sink.sv
// Directed bench for the frame sink: WIDTH=4, element re = tag*256 + row*16 + col, im = ~re.
module tb_fft_2d_frame_sink;

    localparam int W      = 4;
    localparam int DW     = 16;
    localparam int ROW_W  = W * 2 * DW;
    localparam int TILE_W = W * ROW_W;

    logic              clk;
    logic              reset;
    logic              next_out;
    logic [TILE_W-1:0] frame_in;
    logic              m_valid;
    logic              m_ready;
    logic [ROW_W-1:0]  m_data;
    logic [1:0]        m_row;
    logic              m_last;
    logic [1:0]        occupancy;
    logic              overflow;
    logic              clr_ovf;
    logic [7:0]        drop_cnt;

    int total;
    int bad;

    fft_2d_frame_sink #(.WIDTH(W), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .next_out  (next_out),
        .frame_in  (frame_in),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_row     (m_row),
        .m_last    (m_last),
        .occupancy (occupancy),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ROW_W-1:0] make_row(input int tag, input int r);
        logic [ROW_W-1:0] row;
        logic [DW-1:0]    re;
        row = '0;
        for (int c = 0; c < W; c++) begin
            re = 16'(tag * 256 + r * 16 + c);
            row[c*2*DW +: 2*DW] = {~re, re};
        end
        return row;
    endfunction

    function automatic logic [TILE_W-1:0] make_tile(input int tag);
        logic [TILE_W-1:0] t;
        for (int r = 0; r < W; r++) begin
            t[r*ROW_W +: ROW_W] = make_row(tag, r);
        end
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // next_out in the current cycle, tile on the following one; returns when the frame is visible.
    task automatic send_frame(input int tag);
        next_out = 1'b1;
        frame_in = make_tile(8'hEE);
        tick();
        next_out = 1'b0;
        frame_in = make_tile(tag);
        tick();
        frame_in = make_tile(8'hEE);
        $display("frame sent tag=%0d occ=%0d", tag, occupancy);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        next_out = 1'b0;
        m_ready = 1'b0;
        clr_ovf = 1'b0;
        frame_in = make_tile(8'hEE);
        repeat (3) tick();
        total++;
        if (m_valid !== 1'b0 || occupancy !== 2'd0 || m_data !== '0 || m_row !== 2'd0 || m_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: got v=%b occ=%0d row=%0d last=%b want all 0", m_valid, occupancy, m_row, m_last);
        end
        reset = 1'b1;
        tick();
        total++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0 || m_valid !== 1'b0 || occupancy !== 2'd0) begin
            bad++;
            $display("FAIL reset_release: got ovf=%b drop=%0d v=%b occ=%0d want 0", overflow, drop_cnt, m_valid, occupancy);
        end
    endtask

    task automatic test_single();
        m_ready = 1'b1;
        next_out = 1'b1;
        tick();
        next_out = 1'b0;
        frame_in = make_tile(1);
        total++;
        if (m_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_early_valid: got %b want 0", m_valid);
        end
        tick();
        frame_in = make_tile(8'hEE);
        for (int r = 0; r < W; r++) begin
            total++;
            if (m_valid !== 1'b1 || m_row !== 2'(r) || m_last !== (r == W - 1) || m_data !== make_row(1, r)) begin
                bad++;
                $display("FAIL single_beat: got v=%b row=%0d last=%b data=%h want v=1 row=%0d data=%h", m_valid, m_row, m_last, m_data, r, make_row(1, r));
            end
            $display("beat tag=1 row=%0d data=%h", m_row, m_data);
            tick();
        end
        total++;
        if (occupancy !== 2'd0 || m_valid !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL single_empty: got occ=%0d v=%b ovf=%b want 0 0 0", occupancy, m_valid, overflow);
        end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        send_frame(2);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (m_valid !== 1'b1 || m_row !== 2'd0 || m_data !== make_row(2, 0) || m_last !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold: got v=%b row=%0d data=%h want v=1 row=0 data=%h", m_valid, m_row, m_data, make_row(2, 0));
            end
            tick();
        end
        m_ready = 1'b1;
        for (int r = 0; r < W; r++) begin
            total++;
            if (m_valid !== 1'b1 || m_row !== 2'(r) || m_last !== (r == W - 1) || m_data !== make_row(2, r)) begin
                bad++;
                $display("FAIL bp_beat: got v=%b row=%0d data=%h want row=%0d data=%h", m_valid, m_row, m_data, r, make_row(2, r));
            end
            $display("beat tag=2 row=%0d data=%h", m_row, m_data);
            tick();
        end
        total++;
        if (m_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_extra_beat: got v=%b want 0", m_valid);
        end
    endtask

    task automatic test_two_frames();
        int tag;
        m_ready = 1'b0;
        send_frame(3);
        send_frame(4);
        total++;
        if (occupancy !== 2'd2 || m_data !== make_row(3, 0)) begin
            bad++;
            $display("FAIL two_occ: got occ=%0d data=%h want occ=2 data=%h", occupancy, m_data, make_row(3, 0));
        end
        m_ready = 1'b1;
        for (int b = 0; b < 2 * W; b++) begin
            tag = (b < W) ? 3 : 4;
            total++;
            if (m_valid !== 1'b1 || m_row !== 2'(b % W) || m_data !== make_row(tag, b % W)) begin
                bad++;
                $display("FAIL two_beat: got v=%b row=%0d data=%h want tag=%0d row=%0d", m_valid, m_row, m_data, tag, b % W);
            end
            $display("beat tag=%0d row=%0d data=%h", tag, m_row, m_data);
            tick();
        end
        total++;
        if (occupancy !== 2'd0) begin
            bad++;
            $display("FAIL two_empty: got occ=%0d want 0", occupancy);
        end
    endtask

    task automatic test_back_to_back();
        int tag;
        m_ready = 1'b0;
        next_out = 1'b1;
        tick();
        frame_in = make_tile(12);
        tick();
        next_out = 1'b0;
        frame_in = make_tile(13);
        tick();
        frame_in = make_tile(8'hEE);
        total++;
        if (occupancy !== 2'd2 || drop_cnt !== 8'd0) begin
            bad++;
            $display("FAIL b2b_capture: got occ=%0d drop=%0d want 2 0", occupancy, drop_cnt);
        end
        m_ready = 1'b1;
        for (int b = 0; b < 2 * W; b++) begin
            tag = (b < W) ? 12 : 13;
            total++;
            if (m_valid !== 1'b1 || m_row !== 2'(b % W) || m_data !== make_row(tag, b % W)) begin
                bad++;
                $display("FAIL b2b_beat: got row=%0d data=%h want tag=%0d row=%0d", m_row, m_data, tag, b % W);
            end
            $display("beat tag=%0d row=%0d data=%h", tag, m_row, m_data);
            tick();
        end
    endtask

    task automatic test_drop();
        int tag;
        m_ready = 1'b0;
        send_frame(5);
        send_frame(6);
        send_frame(7);
        total++;
        if (overflow !== 1'b1 || drop_cnt !== 8'd1 || occupancy !== 2'd2) begin
            bad++;
            $display("FAIL drop_flag: got ovf=%b drop=%0d occ=%0d want 1 1 2", overflow, drop_cnt, occupancy);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        total++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            bad++;
            $display("FAIL drop_clear: got ovf=%b drop=%0d want 0 0", overflow, drop_cnt);
        end
        next_out = 1'b1;
        tick();
        tick();
        next_out = 1'b0;
        tick();
        total++;
        if (overflow !== 1'b1 || drop_cnt !== 8'd2) begin
            bad++;
            $display("FAIL drop_b2b: got ovf=%b drop=%0d want 1 2", overflow, drop_cnt);
        end
        next_out = 1'b1;
        tick();
        next_out = 1'b0;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        total++;
        if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
            bad++;
            $display("FAIL drop_vs_clear: got ovf=%b drop=%0d want 1 1", overflow, drop_cnt);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        m_ready = 1'b1;
        for (int b = 0; b < 2 * W; b++) begin
            tag = (b < W) ? 5 : 6;
            total++;
            if (m_valid !== 1'b1 || m_row !== 2'(b % W) || m_data !== make_row(tag, b % W)) begin
                bad++;
                $display("FAIL drop_beat: got row=%0d data=%h want tag=%0d row=%0d", m_row, m_data, tag, b % W);
            end
            $display("beat tag=%0d row=%0d data=%h", tag, m_row, m_data);
            tick();
        end
        total++;
        if (occupancy !== 2'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL drop_end: got occ=%0d ovf=%b want 0 0", occupancy, overflow);
        end
    endtask

    task automatic test_same_cycle_last();
        int tags [3];
        tags = '{8, 9, 10};
        m_ready = 1'b0;
        send_frame(8);
        send_frame(9);
        m_ready = 1'b1;
        for (int b = 0; b < 3 * W; b++) begin
            if (b == W) begin
                frame_in = make_tile(8'hEE);
                total++;
                if (occupancy !== 2'd2 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
                    bad++;
                    $display("FAIL swap_accept: got occ=%0d ovf=%b drop=%0d want 2 0 0", occupancy, overflow, drop_cnt);
                end
            end
            total++;
            if (m_valid !== 1'b1 || m_row !== 2'(b % W) || m_data !== make_row(tags[b / W], b % W)) begin
                bad++;
                $display("FAIL swap_beat: got row=%0d data=%h want tag=%0d row=%0d", m_row, m_data, tags[b / W], b % W);
            end
            $display("beat tag=%0d row=%0d data=%h", tags[b / W], m_row, m_data);
            if (b == W - 2) next_out = 1'b1;
            if (b == W - 1) begin
                next_out = 1'b0;
                frame_in = make_tile(10);
            end
            tick();
        end
        total++;
        if (occupancy !== 2'd0) begin
            bad++;
            $display("FAIL swap_empty: got occ=%0d want 0", occupancy);
        end
    endtask

    task automatic test_async_reset();
        m_ready = 1'b0;
        send_frame(11);
        m_ready = 1'b1;
        tick();
        tick();
        total++;
        if (m_row !== 2'd2 || m_data !== make_row(11, 2)) begin
            bad++;
            $display("FAIL ar_pre: got row=%0d data=%h want row=2", m_row, m_data);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (m_valid !== 1'b0 || occupancy !== 2'd0 || m_row !== 2'd0 || m_data !== '0 || m_last !== 1'b0) begin
            bad++;
            $display("FAIL ar_immediate: got v=%b occ=%0d row=%0d want 0 0 0", m_valid, occupancy, m_row);
        end
        tick();
        reset = 1'b1;
        tick();
        total++;
        if (m_valid !== 1'b0 || occupancy !== 2'd0) begin
            bad++;
            $display("FAIL ar_stale: got v=%b occ=%0d want 0 0", m_valid, occupancy);
        end
        send_frame(14);
        for (int r = 0; r < W; r++) begin
            total++;
            if (m_valid !== 1'b1 || m_row !== 2'(r) || m_data !== make_row(14, r)) begin
                bad++;
                $display("FAIL ar_beat: got v=%b row=%0d data=%h want row=%0d data=%h", m_valid, m_row, m_data, r, make_row(14, r));
            end
            $display("beat tag=14 row=%0d data=%h", m_row, m_data);
            tick();
        end
        total++;
        if (m_valid !== 1'b0) begin
            bad++;
            $display("FAIL ar_extra: got v=%b want 0", m_valid);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_two_frames();
        test_back_to_back();
        test_drop();
        test_same_cycle_last();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
